// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 constants: exception codes, register numbers, field positions and the
// Cause word packing used by the register file.
package cp0_regfile_pkg;

  localparam logic [4:0] NO_EX    = 5'h1f;
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int STATUS_IE  = 0;
  localparam int STATUS_EXL = 1;
  localparam int CAUSE_BD   = 31;
  localparam int CAUSE_TI   = 30;

  // IM[15:8], EXL and IE are the only software-writable Status bits
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  function automatic logic [31:0] pack_cause(input logic bd, input logic ti,
                                             input logic [5:0] ip_hw, input logic [1:0] ip_sw,
                                             input logic [4:0] exc_code);
    return {bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, exc_code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances once every COUNT_DIV clocks, TI latches a
// Count==Compare match and is cleared by a Compare write.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam int               DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      compare_q, compare_d;
  logic             ti_q, ti_d;

  always_comb begin
    div_d     = div_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    // a software load restarts the divider phase so the new value holds a full period
    if (count_we) begin
      count_d = wdata;
      div_d   = '0;
    end else if (div_q == DIV_LAST) begin
      count_d = count_q + 32'd1;
      div_d   = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    if (compare_we) begin
      compare_d = wdata;
      ti_d      = 1'b0;
    end else if (!count_we && (count_q == compare_q)) begin
      ti_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign ti      = ti_q;

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file answering the write-back stage: mfc0 reads, mtc0 writes,
// exception commit and eret, plus the interrupt request for decode.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter int          COUNT_DIV    = 2,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  raddr,
  output logic [31:0] rdata,
  input  logic        mtc0,
  input  logic [4:0]  mtc0_waddr,
  input  logic [31:0] mtc0_wdata,
  input  logic [4:0]  ex_code,
  input  logic        slot,
  input  logic        eret,
  input  logic [31:0] ex_pc,
  input  logic [31:0] badvaddr,
  input  logic        pc_error,
  input  logic [5:0]  ext_int,
  output logic [31:0] epc,
  output logic [31:0] status,
  output logic [31:0] cause,
  output logic        int_req
);

  // Every commit is qualified by wb_valid; an exception wins over a same-cycle mtc0/eret.
  logic ex_v, er_v, mt_v;
  assign ex_v = wb_valid & (ex_code != NO_EX);
  assign er_v = wb_valid & eret & ~ex_v;
  assign mt_v = wb_valid & mtc0 & ~ex_v;

  logic [31:0] status_q, status_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        bd_q, bd_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [5:0]  ip_hw_q, ip_hw_d;
  logic [1:0]  ip_sw_q, ip_sw_d;

  logic [31:0] count, compare;
  logic        ti;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mt_v && (mtc0_waddr == CP0_COUNT)),
    .compare_we (mt_v && (mtc0_waddr == CP0_COMPARE)),
    .wdata      (mtc0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = {ext_int[5] | ti, ext_int[4:0]};

    if (mt_v) begin
      case (mtc0_waddr)
        CP0_STATUS: status_d = (status_q & ~STATUS_WMASK) | (mtc0_wdata & STATUS_WMASK);
        CP0_CAUSE:  ip_sw_d  = mtc0_wdata[9:8];
        CP0_EPC:    epc_d    = mtc0_wdata;
        default:    ;
      endcase
    end

    if (ex_v) begin
      status_d[STATUS_EXL] = 1'b1;
      exc_code_d           = ex_code;
      // nested exceptions keep the original return point
      if (!status_q[STATUS_EXL]) begin
        epc_d = slot ? (ex_pc - 32'd4) : ex_pc;
        bd_d  = slot;
      end
      if ((ex_code == EXC_ADEL) || (ex_code == EXC_ADES))
        badvaddr_d = pc_error ? ex_pc : badvaddr;
    end else if (er_v) begin
      status_d[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q   <= RESET_STATUS;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exc_code_q <= '0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
    end
  end

  assign cause   = pack_cause(bd_q, ti, ip_hw_q, ip_sw_q, exc_code_q);
  assign status  = status_q;
  assign epc     = epc_q;
  assign int_req = status_q[STATUS_IE] & ~status_q[STATUS_EXL] & (|(cause[15:8] & status_q[15:8]));

  always_comb begin
    rdata = '0;
    case (raddr)
      CP0_BADVADDR: rdata = badvaddr_q;
      CP0_COUNT:    rdata = count;
      CP0_COMPARE:  rdata = compare;
      CP0_STATUS:   rdata = status_q;
      CP0_CAUSE:    rdata = cause;
      CP0_EPC:      rdata = epc_q;
      default:      rdata = '0;
    endcase
  end

endmodule
